tdm_demux: RTL

Receive-side demultiplexer for a time-division-multiplexed word stream. A transmitter built from `mux` instances and a channel counter serialises N channels onto one bus, one channel per beat, and flags channel 0 with a start-of-frame bit. This block reassembles each frame into a parallel N-channel word, presents it with a valid/ready handshake, and detects framing errors. It sits between the serial link and the parallel consumer.

---
 rtl/tdm_demux.sv | 127 ++++++++++++
 1 files changed

// File: rtl/tdm_demux.sv
// TDM frame reassembler: collects N_CH serial beats, starting at an SOF beat, into one parallel
// word presented with valid/ready, and pulses sync_err on an early SOF.
// Optional saturating error counter on port err_cnt, enabled by defining TDM_DEMUX_ERR_CNT_EN.
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [W-1:0]    in_data,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_CH*W-1:0] out_data,
  output logic            sync_err
`ifdef TDM_DEMUX_ERR_CNT_EN
  ,
  output logic [7:0]      err_cnt
`endif
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  typedef enum logic [1:0] {HUNT, FILL, HOLD} state_t;

  state_t                   state, state_n;
  logic [IDX_W-1:0]         idx, idx_n;
  logic [N_CH-1:0][W-1:0]   slot;
  logic                     accept;
  logic                     wr_en;
  logic [IDX_W-1:0]         wr_idx;
  logic                     err_n;

  assign in_ready = (state != HOLD) || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_data = slot;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    wr_en   = 1'b0;
    wr_idx  = '0;
    err_n   = 1'b0;
    case (state)
      HUNT: begin
        if (accept && in_sof) begin
          wr_en   = 1'b1;
          idx_n   = IDX_W'(1);
          state_n = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (in_sof) begin
            // Early SOF: drop the partial frame and restart on this beat.
            err_n = 1'b1;
            idx_n = IDX_W'(1);
          end else begin
            wr_idx = idx;
            if (idx == LAST_IDX) begin
              idx_n   = '0;
              state_n = HOLD;
            end else begin
              idx_n = idx + IDX_W'(1);
            end
          end
        end
      end
      HOLD: begin
        // A consumed frame frees the slots; the same-cycle beat is handled as in HUNT.
        if (out_ready) begin
          state_n = HUNT;
          if (accept && in_sof) begin
            wr_en   = 1'b1;
            idx_n   = IDX_W'(1);
            state_n = FILL;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      idx       <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      out_valid <= (state_n == HOLD);
      sync_err  <= err_n;
    end
  end

  // NOTE: the slot array is reset because out_data must read zero after reset; a storage
  // array that is never observed before being written would not need it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < N_CH; k++) begin
        if (wr_idx == IDX_W'(k)) slot[k] <= in_data;
      end
    end
  end

`ifdef TDM_DEMUX_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_n && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
